// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: one instruction word plus its PC, valid/ready.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            if_ready;

   modport master (
      output if_valid, if_instr, if_pc,
      input  if_ready
   );

   modport slave (
      input  if_valid, if_instr, if_pc,
      output if_ready
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, register read, ID/EX register, stall/flush/bubble.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback into operands.
module decode_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   decode_stage_if.slave      fetch,
   output logic [RADDR_W-1:0] a_reg,
   output logic [RADDR_W-1:0] b_reg,
   input  logic [XLEN-1:0]    a,
   input  logic [XLEN-1:0]    b,
   input  logic               write_back_en,
   input  logic [RADDR_W-1:0] write_back_reg,
   input  logic [XLEN-1:0]    write_back,
   input  logic               ex_ready,
   input  logic               ex_flush,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [5:0]         ex_opcode,
   output logic [5:0]         ex_funct,
   output logic [XLEN-1:0]    ex_rs_val,
   output logic [XLEN-1:0]    ex_rt_val,
   output logic [XLEN-1:0]    ex_imm,
   output logic [RADDR_W-1:0] ex_dest_reg,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               ex_illegal
);

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [5:0]         opcode;
      logic [5:0]         funct;
      logic [XLEN-1:0]    rs_val;
      logic [XLEN-1:0]    rt_val;
      logic [XLEN-1:0]    imm;
      logic [RADDR_W-1:0] dest;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               illegal;
   } id_ex_t;

   typedef enum logic {RUN, BUBBLE} state_t;

   id_ex_t q;
   id_ex_t d;
   logic   v;
   state_t state;

   logic [XLEN-1:0]    instr;
   logic [5:0]         op;
   logic [5:0]         fn;
   logic [RADDR_W-1:0] rs;
   logic [RADDR_W-1:0] rt;
   logic [RADDR_W-1:0] rd;
   logic [XLEN-1:0]    rs_val;
   logic [XLEN-1:0]    rt_val;
   logic [XLEN-1:0]    imm_s;
   logic [XLEN-1:0]    imm_z;
   logic [XLEN-1:0]    imm_u;
   logic [XLEN-1:0]    imm_j;

   logic is_r, is_alus, is_aluz, is_lui;
   logic is_lw, is_sw, is_br, is_j, is_jal;
   logic hz, accept, hold;

   assign instr = fetch.if_instr;
   assign op    = instr[31:26];
   assign fn    = instr[5:0];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign a_reg = rs;
   assign b_reg = rt;

   assign imm_s = {{(XLEN-16){instr[15]}}, instr[15:0]};
   assign imm_z = {{(XLEN-16){1'b0}}, instr[15:0]};
   assign imm_u = {instr[15:0], {(XLEN-16){1'b0}}};
   assign imm_j = {{(XLEN-26){1'b0}}, instr[25:0]};

`ifdef REGFILE_BYPASS_EN
   assign rs_val = (write_back_en && write_back_reg == rs && rs != '0)
                 ? write_back : a;
   assign rt_val = (write_back_en && write_back_reg == rt && rt != '0)
                 ? write_back : b;
`else
   logic unused_wb;
   assign unused_wb = ^{write_back_en, write_back_reg, write_back};
   assign rs_val = a;
   assign rt_val = b;
`endif

   assign is_r    = op == 6'h00;
   assign is_alus = op inside {[6'h08:6'h0B]};
   assign is_aluz = op inside {[6'h0C:6'h0E]};
   assign is_lui  = op == 6'h0F;
   assign is_lw   = op == 6'h23;
   assign is_sw   = op == 6'h2B;
   assign is_br   = op == 6'h04 || op == 6'h05;
   assign is_j    = op == 6'h02;
   assign is_jal  = op == 6'h03;

   always_comb begin
      d        = '0;
      d.pc     = fetch.if_pc;
      d.opcode = op;
      d.funct  = fn;
      d.rs_val = rs_val;
      d.rt_val = rt_val;
      unique case (1'b1)
         is_r: begin
            d.dest      = rd;
            d.reg_write = fn != 6'h08;
         end
         is_alus: begin
            d.imm       = imm_s;
            d.dest      = rt;
            d.reg_write = 1'b1;
         end
         is_aluz: begin
            d.imm       = imm_z;
            d.dest      = rt;
            d.reg_write = 1'b1;
         end
         is_lui: begin
            d.imm       = imm_u;
            d.dest      = rt;
            d.reg_write = 1'b1;
         end
         is_lw: begin
            d.imm       = imm_s;
            d.dest      = rt;
            d.reg_write = 1'b1;
            d.mem_read  = 1'b1;
         end
         is_sw: begin
            d.imm       = imm_s;
            d.mem_write = 1'b1;
         end
         is_br: d.imm = imm_s;
         is_j:  d.imm = imm_j;
         is_jal: begin
            d.imm       = imm_j;
            d.dest      = 5'd31;
            d.reg_write = 1'b1;
         end
         default: d.illegal = 1'b1;
      endcase
      // $zero is never a real destination
      if (d.dest == '0) d.reg_write = 1'b0;
   end

   assign hz = v && q.mem_read && q.dest != '0
            && (q.dest == rs || q.dest == rt);

   assign fetch.if_ready = rst
                        && (ex_flush || ((!v || ex_ready) && !hz));

   assign accept = fetch.if_valid && fetch.if_ready;
   assign hold   = v && !ex_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v     <= 1'b0;
         q     <= '0;
         state <= RUN;
      end else if (ex_flush) begin
         v     <= 1'b0;
         state <= RUN;
      end else begin
         case (state)
            RUN:    state <= (hz && ex_ready) ? BUBBLE : RUN;
            BUBBLE: state <= RUN;
         endcase
         if (!hold) begin
            if (accept) begin
               v <= 1'b1;
               q <= d;
            end else begin
               v <= 1'b0;
            end
         end
      end
   end

   assign ex_valid     = v;
   assign ex_pc        = q.pc;
   assign ex_opcode    = q.opcode;
   assign ex_funct     = q.funct;
   assign ex_rs_val    = q.rs_val;
   assign ex_rt_val    = q.rt_val;
   assign ex_imm       = q.imm;
   assign ex_dest_reg  = q.dest;
   assign ex_reg_write = q.reg_write;
   assign ex_mem_read  = q.mem_read;
   assign ex_mem_write = q.mem_write;
   assign ex_illegal   = q.illegal;

endmodule
